// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Digit-serial subtractor: diff = (a - b - bin) mod 2^WIDTH, computed DIGIT
// bits per clock over NDIG = WIDTH/DIGIT cycles. A single subtract-with-borrow
// cell is reused each cycle. The borrow between digits lives in a register.
//
// Parameters
//   WIDTH  operand/result width
//   DIGIT  bits processed per CALC cycle; must divide WIDTH
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   a, b, bin             minuend, subtrahend, borrow-in
//   out_valid / out_ready result handshake (out_valid only in DONE)
//   diff                  (a - b - bin) mod 2^WIDTH
//   borrow                unsigned borrow-out (a < b + bin)
//   ovf                   two's-complement overflow of a - b - bin
//   zero                  diff == 0
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, diff_sh, diff_nxt;
  logic             brw;
  logic             a_msb, b_msb;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dig;
  logic             last;

  // One DIGIT-wide subtract-with-borrow; the extra top bit is the borrow-out.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    dig      = '0;
    diff_nxt = '0;
    dig      = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]}
             - {{DIGIT{1'b0}}, brw};
    // New digit enters from the MSB side; after NDIG digits the first digit
    // has migrated down to bit 0.
    diff_nxt = diff_sh >> DIGIT;
    diff_nxt[WIDTH-1 -: DIGIT] = dig[DIGIT-1:0];
  end

  assign last = (cnt == CW'(NDIG - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their inputs from the same pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Handshake flags decode straight from the state register, so they carry no
  // combinational path from any input.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath is a handful of flops, not a memory array, so it is
    // cleared on reset along with the state; the result outputs must read 0.
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      brw     <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      cnt     <= '0;
      diff    <= '0;
      borrow  <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
          end
        end
        CALC: begin
          a_sh    <= a_sh >> DIGIT;
          b_sh    <= b_sh >> DIGIT;
          diff_sh <= diff_nxt;
          brw     <= dig[DIGIT];
          cnt     <= cnt + 1'b1;
          if (last) begin
            diff   <= diff_nxt;
            borrow <= dig[DIGIT];
            // Overflow only possible when operand signs differ; it occurred
            // if the result sign disagrees with the minuend's sign.
            ovf    <= (a_msb ^ b_msb) & (diff_nxt[WIDTH-1] ^ a_msb);
            zero   <= (diff_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Three instances (DIGIT = 1, 4, 16; WIDTH = 16) share all inputs. Directed
// scenarios check the DIGIT=4 instance against hand-computed values; the
// random sweep checks all three against an arithmetic reference model.
// Index 0 = DIGIT 1, index 1 = DIGIT 4, index 2 = DIGIT 16.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a, b;
  logic        bin;

  logic        ir[3], ov[3], br[3], of[3], zr[3];
  logic [15:0] df[3];

  int checks = 0;
  int errors = 0;

  // Per-instance capture from run_all
  int          lat[3];
  logic [15:0] r_df[3];
  logic        r_br[3], r_of[3], r_zr[3];
  logic        r_ov_after[3], r_ir_after[3];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a), .b(b), .bin(bin), .out_valid(ov[0]), .out_ready(out_ready),
    .diff(df[0]), .borrow(br[0]), .ovf(of[0]), .zero(zr[0]));

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a), .b(b), .bin(bin), .out_valid(ov[1]), .out_ready(out_ready),
    .diff(df[1]), .borrow(br[1]), .ovf(of[1]), .zero(zr[1]));

  serial_subtractor #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a), .b(b), .bin(bin), .out_valid(ov[2]), .out_ready(out_ready),
    .diff(df[2]), .borrow(br[2]), .ovf(of[2]), .zero(zr[2]));

  function automatic int ndig_of(input int idx);
    case (idx)
      0:       return 16;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  // Reference: {diff, borrow, ovf, zero} from plain integer arithmetic.
  function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mbin);
    logic [16:0] full;
    int          s;
    logic        m_ovf;
    full  = {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
    s     = int'($signed(ma)) - int'($signed(mb)) - (mbin ? 1 : 0);
    m_ovf = (s > 32767) || (s < -32768);
    return {full[15:0], full[16], m_ovf, (full[15:0] == 16'd0)};
  endfunction

  task automatic wait_all_idle();
    int n = 0;
    while (!(ir[0] && ir[1] && ir[2]) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL idle_timeout: in_ready=%b%b%b required 111", ir[0], ir[1], ir[2]);
    end
  endtask

  // Issue one operation with out_ready=1 and watch all three instances.
  // Label c = number of rising edges since the acceptance edge.
  task automatic run_all(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tbin, input bit scramble);
    wait_all_idle();
    out_ready = 1'b1;
    a = ta; b = tb_v; bin = tbin;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0; r_df[i] = 'x; r_br[i] = 'x; r_of[i] = 'x; r_zr[i] = 'x;
      r_ov_after[i] = 'x; r_ir_after[i] = 'x;
    end
    for (int c = 0; c <= 18; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (lat[i] == 0 && ov[i] === 1'b1) begin
          lat[i] = c; r_df[i] = df[i]; r_br[i] = br[i]; r_of[i] = of[i]; r_zr[i] = zr[i];
        end else if (lat[i] != 0 && c == lat[i] + 1) begin
          r_ov_after[i] = ov[i]; r_ir_after[i] = ir[i];
        end
      end
      if (scramble) begin
        a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ir[i], ov[i], df[i], br[i], of[i], zr[i]} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
        errors++;
        $display("FAIL reset_asserted[%0d]: ir=%b ov=%b diff=%h br=%b ovf=%b z=%b required 1 0 0000 0 0 0",
                 i, ir[i], ov[i], df[i], br[i], of[i], zr[i]);
      end
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ir[1], ov[1], df[1], br[1], of[1], zr[1]} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset_released: ir=%b ov=%b diff=%h br=%b ovf=%b z=%b required 1 0 0000 0 0 0",
               ir[1], ov[1], df[1], br[1], of[1], zr[1]);
    end
  endtask

  task automatic test_basic();
    run_all(16'h1234, 16'h0234, 1'b0, 1'b0);
    checks++;
    if (lat[1] != 4) begin
      errors++; $display("FAIL basic_latency: got %0d required 4", lat[1]);
    end
    checks++;
    if ({r_df[1], r_br[1], r_of[1], r_zr[1]} !== {16'h1000, 3'b000}) begin
      errors++;
      $display("FAIL basic_result: diff=%h br=%b ovf=%b z=%b required 1000 0 0 0",
               r_df[1], r_br[1], r_of[1], r_zr[1]);
    end
    checks++;
    if ({r_ov_after[1], r_ir_after[1]} !== 2'b01) begin
      errors++;
      $display("FAIL basic_release: out_valid=%b in_ready=%b required 0 1",
               r_ov_after[1], r_ir_after[1]);
    end
  endtask

  task automatic test_borrow_zero();
    logic [15:0] va[3]   = '{16'h0000, 16'h0005, 16'h0005};
    logic [15:0] vb[3]   = '{16'h0001, 16'h0005, 16'h0005};
    logic        vbin[3] = '{1'b0, 1'b0, 1'b1};
    logic [18:0] vexp[3] = '{{16'hFFFF, 3'b100}, {16'h0000, 3'b001}, {16'hFFFF, 3'b100}};
    for (int v = 0; v < 3; v++) begin
      run_all(va[v], vb[v], vbin[v], 1'b0);
      checks++;
      if ({r_df[1], r_br[1], r_of[1], r_zr[1]} !== vexp[v]) begin
        errors++;
        $display("FAIL borrow_zero[%0d]: got diff/br/ovf/z=%h required %h",
                 v, {r_df[1], r_br[1], r_of[1], r_zr[1]}, vexp[v]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] va[2]   = '{16'h8000, 16'h7FFF};
    logic [15:0] vb[2]   = '{16'h0001, 16'hFFFF};
    logic [18:0] vexp[2] = '{{16'h7FFF, 3'b010}, {16'h8000, 3'b110}};
    for (int v = 0; v < 2; v++) begin
      run_all(va[v], vb[v], 1'b0, 1'b0);
      checks++;
      if ({r_df[1], r_br[1], r_of[1], r_zr[1]} !== vexp[v]) begin
        errors++;
        $display("FAIL overflow[%0d]: got diff/br/ovf/z=%h required %h",
                 v, {r_df[1], r_br[1], r_of[1], r_zr[1]}, vexp[v]);
      end
    end
  endtask

  // 0x4321 - 0x1111 = 0x3210; later operand traffic must not disturb it.
  task automatic test_backpressure();
    int n = 0;
    int bad = 0;
    wait_all_idle();
    out_ready = 1'b0;
    a = 16'h4321; b = 16'h1111; bin = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    while (ov[1] !== 1'b1 && n < 20) begin
      a = 16'($urandom); b = 16'($urandom);
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL bp_latency: got %0d required 4", n);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'(i);
      a = 16'hAAAA ^ 16'(i); b = 16'h0F0F; bin = 1'b1;
      @(negedge clk);
      if ({ov[1], ir[1], df[1], br[1], of[1], zr[1]} !== {2'b10, 16'h3210, 3'b000}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles, last ov=%b ir=%b diff=%h required 1 0 3210",
               bad, ov[1], ir[1], df[1]);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({ov[1], ir[1], df[1]} !== {2'b01, 16'h3210}) begin
      errors++;
      $display("FAIL bp_release: ov=%b ir=%b diff=%h required 0 1 3210", ov[1], ir[1], df[1]);
    end
  endtask

  task automatic test_reset_midop();
    int bad = 0;
    wait_all_idle();
    a = 16'h1111; b = 16'h0001; bin = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);          // now within the 2nd CALC cycle
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ir[1], ov[1], df[1], br[1], of[1], zr[1]} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
      errors++;
      $display("FAIL midop_async_clear: ir=%b ov=%b diff=%h br=%b ovf=%b z=%b required 1 0 0000 0 0 0",
               ir[1], ov[1], df[1], br[1], of[1], zr[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov[1] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL midop_no_result: out_valid high %0d cycles required 0", bad);
    end
    run_all(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    checks++;
    if ({lat[1], r_df[1]} !== {32'd4, 16'hFFFE}) begin
      errors++;
      $display("FAIL midop_next_op: lat=%0d diff=%h required 4 fffe", lat[1], r_df[1]);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] sa, sb;
    logic        sbin;
    logic [18:0] exp_v;
    for (int t = 0; t < 1000; t++) begin
      sa = 16'($urandom); sb = 16'($urandom); sbin = 1'($urandom);
      if (t == 0) begin sa = 16'h8000; sb = 16'h7FFF; sbin = 1'b1; end
      if (t == 1) begin sa = 16'h0000; sb = 16'hFFFF; sbin = 1'b1; end
      exp_v = model(sa, sb, sbin);
      run_all(sa, sb, sbin, 1'b1);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({r_df[i], r_br[i], r_of[i], r_zr[i]} !== exp_v) begin
          errors++;
          $display("FAIL sweep_result[%0d] a=%h b=%h bin=%b: got %h required %h",
                   i, sa, sb, sbin, {r_df[i], r_br[i], r_of[i], r_zr[i]}, exp_v);
        end
        checks++;
        if (lat[i] != ndig_of(i)) begin
          errors++;
          $display("FAIL sweep_latency[%0d]: got %0d required %0d", i, lat[i], ndig_of(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_zero();
    test_overflow();
    test_backpressure();
    test_reset_midop();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
